seqdiv_12_6: RTL and testbench
==============================

# seqdiv_12_6

Sequential restoring divider: 12-bit unsigned dividend by 6-bit unsigned divisor, producing 12-bit quotient and 6-bit remainder. It is the inverse of the team's 6x6 compressor-tree multiplier: it recovers one factor from a 12-bit product and the other factor. It sits beside the multiplier as a verification and decode path and retires one quotient bit per cycle behind a start/done handshake.

## Interface
- `WA`, 12: dividend and quotient width; only the default is verified.
- `WB`, 6: divisor and remainder width; only the default is verified.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a division; honoured only in IDLE.
- `a` input WA: dividend; sampled in the start cycle only.
- `b` input WB: divisor; sampled in the start cycle only.
- `busy` output 1: high from the cycle after start acceptance until DONE is left.
- `done` output 1: one-cycle pulse; `q`, `r` and `dz` are valid in that cycle and afterwards.
- `dz` output 1: divide-by-zero flag for the last result.
- `q` output WA: quotient.
- `r` output WB: remainder.

## Operation
- States:
  - IDLE: `start`=1 captures `a` into the dividend shift register and `b` into the divisor register, and clears `q`, `r`, `dz`.
    - `b`≠0: go to RUN, count=WA-1.
    - `b`=0: go to DONE directly.
  - RUN, one step per cycle, working from the dividend MSB down:
    - pr = {pr[WB-1:0], next dividend bit}, with pr being WB+1 bits.
    - If pr ≥ {1'b0,b}: pr = pr−b and the quotient bit is 1; otherwise pr is unchanged and the quotient bit is 0.
    - The quotient shifts in at the LSB.
    - count==0: go to DONE; otherwise count decrements.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Arithmetic: pr is WB+1 = 7 bits with an unsigned compare/subtract. The final pr[WB] is always 0, and `r` = pr[WB-1:0].
- Divide-by-zero: `q`=12'hFFF, `r`=6'd0, `dz`=1.
- Results hold in `q`/`r`/`dz` after DONE until the next accepted start clears them.
- `start` asserted in RUN or DONE is ignored and is not queued.
- `a` and `b` are don't-care outside the start cycle.
- Invariant for `dz`=0: q·b + r == a, and r < b.

## Timing
- Reset values:
  - state=IDLE, count=0, pr=0.
  - `busy`=0, `done`=0, `dz`=0, `q`=0, `r`=0.
- Reset asserted mid-RUN aborts the operation; reset values appear the cycle after `rst` is sampled high.
- Latency for a normal divide (start sampled at edge T0):
  - RUN occupies T1..T12.
  - `done`=1 during cycle T13.
  - IDLE is re-entered at T14, and the earliest next start is sampled at T14.
- Latency for divide-by-zero: `done`=1 in the cycle after acceptance (T1).
- `busy` is high T1..T13 for a normal divide, and T1 only for divide-by-zero.
- `busy` and `done` are registered outputs with no combinational path from inputs.
- Throughput: one divide per 14 cycles.

## Structure
- Shared package `arith_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the constants `DIV_WA`=12 and `DIV_WB`=6;
  - the divide-by-zero quotient constant `DIV_DZ_Q`=12'hFFF.
- One sub-module, `divstep_7`: combinational restoring step.
  - Inputs: 7-bit shifted pr and 6-bit divisor.
  - Outputs: next 7-bit pr and quotient bit.
  - It is instantiated once and reused every RUN cycle.
- Top level holds the FSM, the 4-bit counter, the dividend/quotient shift registers and the output registers.

## Test plan
- `a`=3599, `b`=61 with a start pulse → `done` at T13, `q`=59, `r`=0, `dz`=0, `busy` high T1..T13.
- `a`=100, `b`=7 → `q`=14, `r`=2. Also `a`=4095, `b`=63 → `q`=65, `r`=0. Also `a`=4095, `b`=1 → `q`=4095, `r`=0.
- `a`=50, `b`=0 → `done` at T1, `q`=12'hFFF, `r`=0, `dz`=1. A following `a`=9, `b`=3 → `dz`=0, `q`=3, `r`=0.
- Divide in progress, `start` held high with new operands T1..T13 → result unaffected. The next division begins only when `start` is sampled at T14.
- `rst` asserted at T6 of a divide → all outputs 0 and IDLE the next cycle. A fresh `a`=77, `b`=5 → `q`=15, `r`=2.
- Exhaustive sweep: all a∈[0,4095], b∈[1,63] → q·b+r==a and r<b. Cross-check by multiplying `q` and `b` through the 6x6 multiplier when q<64.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the multiplier/divider pair.
package arith_pkg;

  // Widths of the sequential divider: 12-bit dividend/quotient, 6-bit divisor/remainder.
  localparam int DIV_WA = 12;
  localparam int DIV_WB = 6;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WA-1:0] DIV_DZ_Q = 12'hFFF;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divstep_7.sv
// One restoring-division step: compare the shifted partial remainder with
// the divisor and subtract when it fits.
module divstep_7 #(
  parameter int WB = 6
) (
  input  logic [WB:0]   pr_in,
  input  logic [WB-1:0] d,
  output logic [WB:0]   pr_out,
  output logic          q_bit
);

  logic [WB:0] d_ext;

  // Restoring step: keep the partial remainder unchanged when the divisor does not fit.
  always_comb begin
    d_ext  = {1'b0, d};
    q_bit  = (pr_in >= d_ext);
    pr_out = q_bit ? (pr_in - d_ext) : pr_in;
  end

endmodule

// File: rtl/seqdiv_12_6.sv
// Sequential restoring divider, one quotient bit per cycle behind a
// start/done handshake. Results hold until the next accepted start.
module seqdiv_12_6
  import arith_pkg::*;
#(
  parameter int WA = DIV_WA,
  parameter int WB = DIV_WB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic [WA-1:0] q,
  output logic [WB-1:0] r
);

  localparam int CW = $clog2(WA);

  div_state_e    state_reg, state_next;
  logic [CW-1:0] count_reg;
  logic [WA-1:0] dvd_reg;   // dividend shift register, consumed MSB first
  logic [WB-1:0] dvs_reg;   // divisor captured at start
  logic [WB:0]   pr_reg;    // partial remainder, one guard bit wide
  logic [WA-1:0] q_reg;
  logic [WB-1:0] r_reg;
  logic          dz_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [WB:0]   pr_shift;
  logic [WB:0]   pr_step;
  logic          q_bit;

  assign pr_shift = {pr_reg[WB-1:0], dvd_reg[WA-1]};

  // Single shared step unit, fed a new dividend bit every RUN cycle.
  divstep_7 #(.WB(WB)) u_step (
    .pr_in  (pr_shift),
    .d      (dvs_reg),
    .pr_out (pr_step),
    .q_bit  (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a zero divisor skips RUN entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (b == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (count_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs (driven from next state so
  // they line up with the state they describe).
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      pr_reg    <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dz_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            dvd_reg   <= a;
            dvs_reg   <= b;
            pr_reg    <= '0;
            r_reg     <= '0;
            count_reg <= CW'(WA - 1);
            if (b == '0) begin
              q_reg  <= WA'(DIV_DZ_Q);
              dz_reg <= 1'b1;
            end else begin
              q_reg  <= '0;
              dz_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd_reg <= {dvd_reg[WA-2:0], 1'b0};
          pr_reg  <= pr_step;
          q_reg   <= {q_reg[WA-2:0], q_bit};
          if (count_reg == '0) begin
            // Guard bit is always clear after the last step.
            r_reg <= pr_step[WB-1:0];
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign dz   = dz_reg;
  assign q    = q_reg;
  assign r    = r_reg;

endmodule

// File: tb/tb_seqdiv_12_6.sv
// Self-checking bench for seqdiv_12_6: directed cases, start-while-busy,
// mid-run reset and a random sweep against plain integer division.
module tb_seqdiv_12_6;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic        dz;
  logic [11:0] q;
  logic [5:0]  r;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seqdiv_12_6 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .q     (q),
    .r     (r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the falling edge inside cycle T1 of a division of ta by tb_.
  // When hold is set, start stays high with fresh random operands throughout.
  task automatic finish_div(input logic [11:0] ta, input logic [5:0] tb_, input bit hold);
    int lat;
    int eq;
    int er;
    lat = (tb_ == 6'd0) ? 1 : 13;
    eq  = (tb_ == 6'd0) ? 4095 : int'(ta) / int'(tb_);
    er  = (tb_ == 6'd0) ? 0 : int'(ta) % int'(tb_);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      if (hold) begin
        a = 12'($urandom);
        b = 6'($urandom);
      end
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_timing", 32'(done), 32'(cyc == lat));
      if (cyc < lat) @(negedge clk);
    end
    chk("q", 32'(q), 32'(eq));
    chk("r", 32'(r), 32'(er));
    chk("dz", 32'(dz), 32'(tb_ == 6'd0));
    if (tb_ != 6'd0) begin
      chk("inv_qb_r", 32'(int'(q) * int'(tb_) + int'(r)), 32'(ta));
      chk("inv_r_lt_b", 32'(r < tb_), 32'd1);
    end
    $display("div a=%0d b=%0d -> q=%0d r=%0d dz=%0d", ta, tb_, q, r, dz);
    @(negedge clk);  // cycle T14: back in IDLE
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_idle", 32'(done), 32'd0);
    chk("q_hold", 32'(q), 32'(eq));
  endtask

  task automatic do_div(input logic [11:0] ta, input logic [5:0] tb_, input bit hold);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_;
    @(negedge clk);  // cycle T1
    if (!hold) begin
      start = 1'b0;
      a     = 12'($urandom);
      b     = 6'($urandom);
    end
    finish_div(ta, tb_, hold);
  endtask

  logic [11:0] ha;
  logic [5:0]  hb;
  logic [11:0] ra;
  logic [5:0]  rb;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);

    // Directed cases, including boundaries and divide-by-zero.
    do_div(12'd3599, 6'd61, 1'b0);
    do_div(12'd100, 6'd7, 1'b0);
    do_div(12'd4095, 6'd63, 1'b0);
    do_div(12'd4095, 6'd1, 1'b0);
    do_div(12'd50, 6'd0, 1'b0);
    do_div(12'd9, 6'd3, 1'b0);
    do_div(12'd0, 6'd1, 1'b0);
    do_div(12'd62, 6'd63, 1'b0);
    do_div(12'd0, 6'd0, 1'b0);

    // Start held high with changing operands during a divide: result unaffected,
    // and the operands present at T14 start the next division.
    do_div(12'd100, 6'd7, 1'b1);
    ha = a;
    hb = b;
    @(negedge clk);  // T1 of the division sampled at T14
    start = 1'b0;
    a     = '0;
    b     = '0;
    finish_div(ha, hb, 1'b0);

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    start = 1'b1;
    a     = 12'd1000;
    b     = 6'd9;
    @(negedge clk);  // T1
    start = 1'b0;
    repeat (5) @(negedge clk);  // T6
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dz", 32'(dz), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_r", 32'(r), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);
    do_div(12'd77, 6'd5, 1'b0);

    // Random sweep.
    for (int i = 0; i < 250; i++) begin
      ra = 12'($urandom_range(0, 4095));
      rb = 6'($urandom_range(0, 63));
      if (i % 50 == 0) rb = 6'd0;
      do_div(ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
